// File: rtl/conm_test_monitor_pkg.sv
// Shared definitions for the CoNM test-status monitor: FSM encodings,
// default riscv-tests register indices and the SoC data width.
package conm_test_monitor_pkg;

    localparam int DATA_WIDTH   = 32;

    localparam int MON_DONE_REG = 26;
    localparam int MON_PASS_REG = 27;
    localparam int MON_TNUM_REG = 3;

    typedef enum logic [2:0] {
        MON_RUN     = 3'd0,
        MON_SETTLE  = 3'd1,
        MON_PASS    = 3'd2,
        MON_FAIL    = 3'd3,
        MON_TIMEOUT = 3'd4
    } mon_state_t;

endpackage

// File: rtl/conm_mon_hart_tracker.sv
// Per-hart shadow of the done / pass / test-number registers, loaded by
// snooping that hart's register-file write port.
module conm_mon_hart_tracker
    import conm_test_monitor_pkg::*;
#(
    parameter int DATA_W   = DATA_WIDTH,
    parameter int DONE_REG = MON_DONE_REG,
    parameter int PASS_REG = MON_PASS_REG,
    parameter int TNUM_REG = MON_TNUM_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              hart_done,
    output logic              hart_pass,
    output logic [DATA_W-1:0] tnum
);

    logic [DATA_W-1:0] done_sh_r;
    logic [DATA_W-1:0] pass_sh_r;
    logic [DATA_W-1:0] tnum_sh_r;
    logic              wr_ok_s;

    // x0 is hardwired zero in the core, so a write to it never reaches a shadow
    assign wr_ok_s = en && we && (waddr != 5'd0);

    // Shadow registers; frozen once the monitor has reached a verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            done_sh_r <= {DATA_W{1'b0}};
            pass_sh_r <= {DATA_W{1'b0}};
            tnum_sh_r <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            if (waddr == 5'(DONE_REG)) done_sh_r <= wdata;
            if (waddr == 5'(PASS_REG)) pass_sh_r <= wdata;
            if (waddr == 5'(TNUM_REG)) tnum_sh_r <= wdata;
        end
    end

    assign hart_done = (done_sh_r == DATA_W'(1));
    assign hart_pass = (pass_sh_r == DATA_W'(1));
    assign tnum      = tnum_sh_r;

endmodule

// File: rtl/conm_test_monitor.sv
// Multi-hart riscv-tests status monitor producing sticky pass/fail/timeout
// verdicts. Define CONM_MON_TIMEOUT_EN to build the RUN-state timeout.
module conm_test_monitor
    import conm_test_monitor_pkg::*;
#(
    parameter int NUM_HARTS   = 1,
    parameter int DATA_W      = DATA_WIDTH,
    parameter int DONE_REG    = MON_DONE_REG,
    parameter int PASS_REG    = MON_PASS_REG,
    parameter int TNUM_REG    = MON_TNUM_REG,
    parameter int SETTLE_CYC  = 10,
    parameter int TIMEOUT_CYC = 10000,
    localparam int HART_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_HARTS-1:0]        we_i,
    input  logic [5*NUM_HARTS-1:0]      waddr_i,
    input  logic [DATA_W*NUM_HARTS-1:0] wdata_i,
    output logic                        done_o,
    output logic                        pass_o,
    output logic                        fail_o,
    output logic                        timeout_o,
    output logic [HART_W-1:0]           fail_hart_o,
    output logic [DATA_W-1:0]           fail_tnum_o,
    output logic [31:0]                 cycle_cnt_o
);

    localparam logic [31:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 32'(SETTLE_CYC - 1) : 32'd0;

    mon_state_t          state_r;
    logic [31:0]         cycle_cnt_r;
    logic [31:0]         settle_cnt_r;
    logic                done_r;
    logic                pass_r;
    logic                fail_r;
    logic                timeout_r;
    logic [HART_W-1:0]   fail_hart_r;
    logic [DATA_W-1:0]   fail_tnum_r;

    logic [NUM_HARTS-1:0] hart_done_s;
    logic [NUM_HARTS-1:0] hart_pass_s;
    logic [DATA_W-1:0]    tnum_s [NUM_HARTS];
    logic                 track_en_s;
    logic                 all_done_s;
    logic                 all_pass_s;
    logic                 timeout_hit_s;
    logic [31:0]          cnt_next_s;
    logic [HART_W-1:0]    fail_idx_s;
    logic [DATA_W-1:0]    fail_tnum_s;

    assign track_en_s = (state_r == MON_RUN) || (state_r == MON_SETTLE);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        conm_mon_hart_tracker #(
            .DATA_W   (DATA_W),
            .DONE_REG (DONE_REG),
            .PASS_REG (PASS_REG),
            .TNUM_REG (TNUM_REG)
        ) u_tracker (
            .clk       (clk),
            .rst       (rst),
            .en        (track_en_s),
            .we        (we_i[h]),
            .waddr     (waddr_i[5*h +: 5]),
            .wdata     (wdata_i[DATA_W*h +: DATA_W]),
            .hart_done (hart_done_s[h]),
            .hart_pass (hart_pass_s[h]),
            .tnum      (tnum_s[h])
        );
    end

    assign all_done_s = &hart_done_s;
    assign all_pass_s = &hart_pass_s;
    assign cnt_next_s = (cycle_cnt_r == 32'hFFFF_FFFF) ? cycle_cnt_r : cycle_cnt_r + 32'd1;

`ifdef CONM_MON_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    assign timeout_hit_s = (state_r == MON_RUN) && (cycle_cnt_r == TIMEOUT_LAST);
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYC);
    assign timeout_hit_s    = 1'b0;
`endif

    // Lowest-index failing hart wins: scan downward so the last hit is the lowest
    always_comb begin
        fail_idx_s  = {HART_W{1'b0}};
        fail_tnum_s = {DATA_W{1'b0}};
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            fail_idx_s  = hart_pass_s[h] ? fail_idx_s  : HART_W'(h);
            fail_tnum_s = hart_pass_s[h] ? fail_tnum_s : tnum_s[h];
        end
    end

    // Verdict FSM with counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= MON_RUN;
            cycle_cnt_r  <= 32'd0;
            settle_cnt_r <= 32'd0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
            fail_hart_r  <= {HART_W{1'b0}};
            fail_tnum_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                MON_RUN: begin
                    cycle_cnt_r <= cnt_next_s;
                    if (all_done_s) begin
                        state_r      <= MON_SETTLE;
                        settle_cnt_r <= 32'd0;
                    end else if (timeout_hit_s) begin
                        state_r   <= MON_TIMEOUT;
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                    end
                end
                MON_SETTLE: begin
                    cycle_cnt_r <= cnt_next_s;
                    if (settle_cnt_r >= SETTLE_LAST) begin
                        done_r <= 1'b1;
                        if (all_pass_s) begin
                            state_r <= MON_PASS;
                            pass_r  <= 1'b1;
                        end else begin
                            state_r     <= MON_FAIL;
                            fail_r      <= 1'b1;
                            fail_hart_r <= fail_idx_s;
                            fail_tnum_r <= fail_tnum_s;
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 32'd1;
                    end
                end
                MON_PASS, MON_FAIL, MON_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= MON_RUN;
                end
            endcase
        end
    end

    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign fail_o      = fail_r;
    assign timeout_o   = timeout_r;
    assign fail_hart_o = fail_hart_r;
    assign fail_tnum_o = fail_tnum_r;
    assign cycle_cnt_o = cycle_cnt_r;

endmodule
